// File: rtl/uart_msg_serializer.sv
// ---------------------------------------------------------------------------
// uart_msg_serializer
//
// Responder end of the controller's outbound message interface. Accepts one
// MSG_BYTES-wide message per uart_out_req handshake, then streams it MSB byte
// first over a valid/ready byte interface that feeds the UART transmitter.
// uart_out_ready stays low from acceptance until the last byte is handed off.
//
// Optional feature (compile-time macro UART_MSG_CHECKSUM_EN):
//   when defined, one extra byte (XOR of all message bytes) is appended to
//   every message in a CHK state before the serializer returns to idle.
//
// Parameters:
//   MSG_BYTES  bytes per message (1..255)
//   CNT_WIDTH  width of the completed-message counter
//
// Ports:
//   clk             system clock
//   n_reset         synchronous, active-low reset
//   uart_out_msg    message from controller
//   uart_out_req    controller requests transfer of uart_out_msg
//   uart_out_ready  serializer can accept a message this cycle (registered)
//   tx_data         byte to UART transmitter
//   tx_valid        tx_data is valid
//   tx_ready        UART transmitter accepts tx_data this cycle
//   msg_count       number of messages fully serialized (wraps)
//   busy            high while a message is held
// ---------------------------------------------------------------------------
module uart_msg_serializer #(
    parameter int unsigned MSG_BYTES = 4,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   n_reset,
    input  logic [MSG_BYTES*8-1:0] uart_out_msg,
    input  logic                   uart_out_req,
    output logic                   uart_out_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [CNT_WIDTH-1:0]   msg_count,
    output logic                   busy
);

    localparam int unsigned MsgW    = MSG_BYTES * 8;
    localparam logic [7:0]  LastIdx = 8'(MSG_BYTES - 1);

`ifdef UART_MSG_CHECKSUM_EN
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StSend = 2'd1,
        StChk  = 2'd2
    } state_e;
`else
    typedef enum logic [0:0] {
        StIdle = 1'b0,
        StSend = 1'b1
    } state_e;
`endif

    state_e               state_q, state_d;
    logic [MsgW-1:0]      shift_q, shift_d;
    logic [7:0]           idx_q, idx_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
`ifdef UART_MSG_CHECKSUM_EN
    logic [7:0]           csum_q, csum_d;
`endif

    logic [7:0] top_byte;
    logic       last_byte;

    assign top_byte  = shift_q[MsgW-1 -: 8];
    assign last_byte = (idx_q == LastIdx);

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (uart_out_req) begin
                    state_d = StSend;
                end
            end
            StSend: begin
                if (tx_ready && last_byte) begin
`ifdef UART_MSG_CHECKSUM_EN
                    state_d = StChk;
`else
                    state_d = StIdle;
`endif
                end
            end
`ifdef UART_MSG_CHECKSUM_EN
            StChk: begin
                if (tx_ready) begin
                    state_d = StIdle;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs: pure decode of registered state, so uart_out_ready and
    // tx_valid never depend combinationally on uart_out_req or tx_ready.
    // -----------------------------------------------------------------------
    always_comb begin
        uart_out_ready = (state_q == StIdle);
        tx_valid       = (state_q != StIdle);
        busy           = (state_q != StIdle);
        tx_data        = top_byte;
`ifdef UART_MSG_CHECKSUM_EN
        if (state_q == StChk) begin
            tx_data = csum_q;
        end
`endif
        msg_count      = cnt_q;
    end

    // -----------------------------------------------------------------------
    // Datapath next-state: shift register, byte index, checksum, counter.
    // In SEND/CHK tx_valid is 1, so tx_ready alone marks a transfer.
    // -----------------------------------------------------------------------
    always_comb begin
        shift_d = shift_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
`ifdef UART_MSG_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        case (state_q)
            StIdle: begin
                if (uart_out_req) begin
                    shift_d = uart_out_msg;
                    idx_d   = 8'd0;
`ifdef UART_MSG_CHECKSUM_EN
                    csum_d  = 8'd0;
`endif
                end
            end
            StSend: begin
                if (tx_ready) begin
                    shift_d = shift_q << 8;
                    idx_d   = idx_q + 8'd1;
`ifdef UART_MSG_CHECKSUM_EN
                    csum_d  = csum_q ^ top_byte;
`else
                    if (last_byte) begin
                        cnt_d = cnt_q + CNT_WIDTH'(1);
                    end
`endif
                end
            end
`ifdef UART_MSG_CHECKSUM_EN
            StChk: begin
                if (tx_ready) begin
                    cnt_d = cnt_q + CNT_WIDTH'(1);
                end
            end
`endif
            default: ;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!n_reset) begin
            shift_q <= '0;
            idx_q   <= 8'd0;
            cnt_q   <= '0;
`ifdef UART_MSG_CHECKSUM_EN
            csum_q  <= 8'd0;
`endif
        end else begin
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
`ifdef UART_MSG_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: doc/uart_msg_serializer.md
Name: uart_msg_serializer

Overview:
- Responder end of the controller's outbound message interface (uart_out_ready / uart_out_msg / uart_out_req).
- Accepts one complete message per handshake and splits it into bytes, MSB byte first.
- Presents the bytes on a valid/ready byte stream that feeds the UART transmitter.
- Holds uart_out_ready low until the whole message has been handed off.

Parameters:
- MSG_BYTES, 4, number of bytes per message; message width is MSG_BYTES*8. Legal range 1..255.
- CNT_WIDTH, 16, width of the completed-message counter.

Ports:
- clk  input  1  system clock
- n_reset  input  1  reset, synchronous, active-low
- uart_out_msg  input  MSG_BYTES*8  message from controller
- uart_out_req  input  1  controller requests transfer of uart_out_msg
- uart_out_ready  output  1  serializer can accept a message this cycle
- tx_data  output  8  byte to UART transmitter
- tx_valid  output  1  tx_data is valid
- tx_ready  input  1  UART transmitter accepts tx_data this cycle
- msg_count  output  CNT_WIDTH  number of messages fully serialized; wraps
- busy  output  1  high while a message is held (state != IDLE)

Behaviour:
- Clock and reset: clk drives all state. n_reset is synchronous, active-low.
- Reset values: state=IDLE, uart_out_ready=1, tx_valid=0, tx_data=0, msg_count=0, busy=0, byte index=0, shift register=0.
- Accept: in IDLE, uart_out_ready=1. On a clk edge with uart_out_req=1, latch uart_out_msg into the shift register, set byte index=0, go to SEND.
- At that same edge, uart_out_ready goes to 0 and tx_valid goes to 1. The first byte is visible one cycle after the accepting req.
- uart_out_req outside IDLE (uart_out_ready=0) is ignored. No latch, no error.
- SEND:
  - tx_data = the current top byte of the shift register; tx_valid=1.
  - A byte transfers on a clk edge with tx_valid=1 and tx_ready=1.
  - On each transfer: shift left 8 bits, increment byte index.
  - While tx_ready=0, tx_data and tx_valid are held stable.
- Last byte (index MSG_BYTES-1) transfers:
  - without the feature: go to IDLE, tx_valid=0, uart_out_ready=1, msg_count+1, all at the same edge;
  - with the feature: go to CHK (see Optional Feature).
- Back-to-back messages: uart_out_ready is high in the cycle after the final transfer. Minimum message period is MSG_BYTES+1 cycles when tx_ready is held at 1.
- msg_count wraps from 2^CNT_WIDTH-1 to 0 with no saturation.
- busy = (state != IDLE), registered with the state.
- uart_out_ready is a registered output, not combinationally dependent on uart_out_req or tx_ready.
- Reset mid-message: the message is discarded with no partial completion. Outputs return to reset values at the reset edge, and msg_count is cleared.
- MSG_BYTES=1: SEND lasts one transfer, then IDLE (or CHK).

Optional Feature:
- Macro: UART_MSG_CHECKSUM_EN.
- Defined:
  - A running XOR of all transferred message bytes is kept. It is cleared on accept and updated on each SEND transfer.
  - After the last message byte, state CHK presents tx_data = XOR of all MSG_BYTES bytes with tx_valid=1, under the same handshake rules.
  - On the checksum transfer: go to IDLE, uart_out_ready=1, msg_count+1.
  - Stream length is MSG_BYTES+1 bytes; minimum period is MSG_BYTES+2 cycles.
- Undefined: no CHK state and no checksum logic. Stream length is MSG_BYTES.

Test Plan:
- Reset, then idle 5 cycles -> uart_out_ready=1, tx_valid=0, msg_count=0, busy=0 throughout.
- MSG_BYTES=4, tx_ready=1, send 0xA1B2C3D4 -> tx_data A1,B2,C3,D4 on four consecutive cycles starting 1 cycle after req. Then uart_out_ready=1, msg_count=1. With UART_MSG_CHECKSUM_EN, a fifth byte 0x04 follows.
- Backpressure: tx_ready=0 for 3 cycles while B2 is presented -> tx_data stays B2 and tx_valid stays 1. Remaining bytes and count are correct afterwards.
- uart_out_req pulsed with 0x11223344 while serializing 0xA1B2C3D4 -> ignored. Only A1..D4 are emitted and msg_count increments by 1.
- n_reset asserted after the B2 transfer -> next cycle tx_valid=0, uart_out_ready=1, msg_count=0. A new message 0x55667788 is then serialized intact.
- CNT_WIDTH=2, send 5 messages -> msg_count reads 1,2,3,0,1.
